// File: rtl/wb_pkg.sv
// Shared widths and the queue entry type for the write-back queue.
package wb_pkg;

  localparam int ADDR_W    = 5;
  localparam int DATA_W    = 32;
  localparam int DEPTH_DEF = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] add;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Circular entry store for the write-back queue: up to two pushes and one pop per cycle.
// Storage is exported so the parent can run the forwarding search.
module wb_fifo
  import wb_pkg::*;
#(
  parameter  int DEPTH = DEPTH_DEF,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_a,
  input  wb_entry_t             entry_a,
  input  logic                  push_b,
  input  wb_entry_t             entry_b,
  input  logic                  pop,
  output wb_entry_t             head,
  output logic [CNT_W-1:0]      count,
  output logic [PTR_W-1:0]      rd_ptr,
  output wb_entry_t [DEPTH-1:0] entries
);

  wb_entry_t [DEPTH-1:0] mem;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      wr_ptr_nxt;

  assign wr_ptr_nxt = wr_ptr + PTR_W'(1);
  assign head       = mem[rd_ptr];
  assign entries    = mem;

  // push_b is only ever raised together with push_a, so slot b lands right after slot a.
  always_ff @(posedge clk) begin
    if (push_a) mem[wr_ptr] <= entry_a;
    if (push_b) mem[wr_ptr_nxt] <= entry_b;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(push_a) + PTR_W'(push_b);
      rd_ptr <= rd_ptr + PTR_W'(pop);
      count  <= count + CNT_W'(push_a) + CNT_W'(push_b) - CNT_W'(pop);
    end
  end

endmodule

// File: rtl/wb_queue.sv
// Write-back queue merging load and ALU results into one register-file write port,
// with a forwarding lookup over pending writes.
module wb_queue
  import wb_pkg::*;
#(
  parameter  int DEPTH = DEPTH_DEF,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_add,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_add,
  input  logic [DATA_W-1:0] alu_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_add,
  output logic [DATA_W-1:0] datain,
  input  logic [ADDR_W-1:0] q_add,
  output logic              q_hit,
  output logic [DATA_W-1:0] q_data,
  output logic              wb_empty
);

  wb_entry_t             ld_entry;
  wb_entry_t             alu_entry;
  wb_entry_t             entry_a;
  wb_entry_t             head;
  wb_entry_t [DEPTH-1:0] entries;
  logic [CNT_W-1:0]      count;
  logic [CNT_W-1:0]      free;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  ld_push;
  logic                  alu_push;
  logic                  push_a;
  logic                  push_b;
  logic                  pop;

  // Readiness looks only at occupancy before this edge's pop, never at address or data.
  assign free      = CNT_W'(DEPTH) - count;
  assign ld_ready  = (free != '0);
  assign alu_ready = (free >= CNT_W'(2)) || ((free != '0) && !ld_valid);

  // Writes to register 0 finish their handshake but are dropped here.
  assign ld_push  = ld_valid  && ld_ready  && (ld_add  != '0);
  assign alu_push = alu_valid && alu_ready && (alu_add != '0);

  assign ld_entry  = '{add: ld_add,  data: ld_data};
  assign alu_entry = '{add: alu_add, data: alu_data};

  // Compact into slots a/b so the load, being older, always goes first.
  assign push_a  = ld_push || alu_push;
  assign push_b  = ld_push && alu_push;
  assign entry_a = ld_push ? ld_entry : alu_entry;
  assign pop     = (count != '0);

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_a  (push_a),
    .entry_a (entry_a),
    .push_b  (push_b),
    .entry_b (alu_entry),
    .pop     (pop),
    .head    (head),
    .count   (count),
    .rd_ptr  (rd_ptr),
    .entries (entries)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en  <= 1'b0;
      wr_add <= '0;
      datain <= '0;
    end else if (pop) begin
      wr_en  <= 1'b1;
      wr_add <= head.add;
      datain <= head.data;
    end else begin
      wr_en  <= 1'b0;
    end
  end

  assign wb_empty = (count == '0) && !wr_en;

  // Walk oldest to youngest so the last match (youngest) wins; output stage is oldest of all.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx    = '0;
    q_hit  = 1'b0;
    q_data = '0;
    if (q_add != '0) begin
      if (wr_en && (wr_add == q_add)) begin
        q_hit  = 1'b1;
        q_data = datain;
      end
      for (int k = 0; k < DEPTH; k++) begin
        idx = rd_ptr + PTR_W'(k);
        if ((CNT_W'(k) < count) && (entries[idx].add == q_add)) begin
          q_hit  = 1'b1;
          q_data = entries[idx].data;
        end
      end
    end
  end

endmodule
